xor_chunk_scheduler: RTL and testbench

XOR_CHUNK_SCHEDULER -- requirements
Module: xor_chunk_scheduler

---
 rtl/xor_chunk_scheduler.sv | 151 +++++++++++++++
 tb/tb_xor_chunk_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_chunk_scheduler.sv
`default_nettype none
// ============================================================================
// xor_chunk_scheduler: round-robin scheduler for 4 requesters that pushes
// each A^B operation through one shared CHUNK_WIDTH Xor unit, one chunk a cycle.
// Optional macro XOR_SCHED_CHECK_EN adds a sticky result self-check on err.
// Revision: 1.0
// ============================================================================
module xor_chunk_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4,
  parameter int NUM_REQ     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [CHUNK_WIDTH-1:0]        chunk_a,
  output logic [CHUNK_WIDTH-1:0]        chunk_b,
  input  logic [CHUNK_WIDTH-1:0]        chunk_f,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [1:0]                    result_id,
  output logic                          err
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [1:0]              ptr_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [DATA_WIDTH-1:0]   result_d;
  logic [1:0]              result_id_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic                    done_q;

  logic [1:0]              win_d;
  logic [1:0]              cand;
  logic                    found;
  logic                    any_req;
  logic                    last_chunk;

  assign any_req    = |req;
  assign last_chunk = (idx_q == LAST_IDX);

  // First asserted request at or after ptr_q, wrapping modulo 4.
  always_comb begin
    win_d = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    result_d = result_q;
    if (state_q == RUN) begin
      result_d[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      result_id_q <= '0;
      gnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            a_q         <= a_in[win_d*DATA_WIDTH +: DATA_WIDTH];
            b_q         <= b_in[win_d*DATA_WIDTH +: DATA_WIDTH];
            result_id_q <= win_d;
            ptr_q       <= win_d + 2'd1;
            idx_q       <= '0;
            gnt_q[win_d] <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          idx_q    <= idx_q + IDX_W'(1);
          if (last_chunk) begin
            idx_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign chunk_a   = (state_q == RUN) ? a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] : '0;
  assign chunk_b   = (state_q == RUN) ? b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign gnt       = gnt_q;
  assign result    = result_q;
  assign result_id = result_id_q;

`ifdef XOR_SCHED_CHECK_EN
  logic err_q;

  // Checked on the final slot write so err rises together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == RUN && last_chunk && (result_d != (a_q ^ b_q))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_chunk_scheduler.sv
`default_nettype none
// ============================================================================
// tb_xor_chunk_scheduler: directed and randomized bench for xor_chunk_scheduler
// with a transaction-level reference model and a per-cycle output compare.
// Revision: 1.0
// ============================================================================
module tb_xor_chunk_scheduler;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int NR = 4;
  localparam int NC = DW / CW;
`ifdef XOR_SCHED_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*DW-1:0] a_in = '0;
  logic [NR*DW-1:0] b_in = '0;
  logic [NR-1:0]   gnt;
  logic [CW-1:0]   chunk_a;
  logic [CW-1:0]   chunk_b;
  logic [CW-1:0]   chunk_f;
  logic            busy;
  logic            done;
  logic [DW-1:0]   result;
  logic [1:0]      result_id;
  logic            err;
  logic            fault_zero = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  assign chunk_f = fault_zero ? '0 : (chunk_a ^ chunk_b);

  always #5 clk = ~clk;

  xor_chunk_scheduler #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .chunk_a(chunk_a), .chunk_b(chunk_b), .chunk_f(chunk_f),
    .busy(busy), .done(done), .result(result), .result_id(result_id), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic timeout_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc_n);
  endtask

  // Model: t = cycles since capture (-1 idle, 0..NC-1 run slot, NC done cycle).
  int              t = -1;
  int              m_w = 0;
  logic [1:0]      m_ptr = '0;
  logic [1:0]      m_rid = '0;
  logic [DW-1:0]   m_a = '0;
  logic [DW-1:0]   m_b = '0;
  logic [DW-1:0]   m_new = '0;
  logic [DW-1:0]   m_res = '0;
  logic            m_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      t = -1; m_ptr = '0; m_rid = '0; m_a = '0; m_b = '0;
      m_new = '0; m_res = '0; m_err = 1'b0;
    end else if (t < 0) begin
      if (req != '0) begin
        m_w = -1;
        for (int k = 0; k < NR; k++)
          if (m_w < 0 && req[(int'(m_ptr) + k) % NR]) m_w = (int'(m_ptr) + k) % NR;
        m_rid = 2'(m_w);
        m_a   = a_in[m_w*DW +: DW];
        m_b   = b_in[m_w*DW +: DW];
        m_new = fault_zero ? '0 : (m_a ^ m_b);
        m_ptr = 2'((m_w + 1) % NR);
        t     = 0;
      end
    end else if (t < NC) begin
      t++;
      if (t == NC) begin
        m_res = m_new;
        if (CHK && (m_new != (m_a ^ m_b))) m_err = 1'b1;
      end
    end else begin
      t = -1;
    end
  end

  logic [NR-1:0] e_gnt;
  logic [CW-1:0] e_ca, e_cb;
  logic [DW-1:0] e_res;

  initial forever begin
    @(negedge clk);
    e_gnt = (t == 0) ? (4'b0001 << m_rid) : 4'b0000;
    e_ca  = '0;
    e_cb  = '0;
    e_res = m_res;
    if (t >= 0 && t < NC) begin
      e_ca = m_a[t*CW +: CW];
      e_cb = m_b[t*CW +: CW];
      for (int s = 0; s < NC; s++)
        if (s < t) e_res[s*CW +: CW] = m_new[s*CW +: CW];
    end
    chk("cyc_gnt", gnt, e_gnt);
    chk("cyc_busy", busy, (t >= 0));
    chk("cyc_done", done, (t == NC));
    chk("cyc_chunk_a", chunk_a, e_ca);
    chk("cyc_chunk_b", chunk_b, e_cb);
    chk("cyc_result", result, e_res);
    chk("cyc_result_id", result_id, m_rid);
    chk("cyc_err", err, m_err);
  end

  task automatic cyc();
    @(posedge clk);
    #3;
    cyc_n++;
  endtask

  task automatic wait_gnt(input int maxc, output logic [NR-1:0] g);
    g = '0;
    for (int i = 0; i < maxc; i++) begin
      cyc();
      if (gnt != '0) begin
        g = gnt;
        return;
      end
    end
    timeout_fail("wait_gnt");
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      cyc();
      if (done) begin
        n = i;
        return;
      end
    end
    timeout_fail("wait_done");
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      cyc();
      if (!busy) return;
    end
    timeout_fail("wait_idle");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] ta [NR];
  logic [DW-1:0] tb [NR];

  initial begin
    logic [NR-1:0] g;
    int n;
    int last_c;

    ta[0] = 16'h1111; ta[1] = 16'h2222; ta[2] = 16'h3333; ta[3] = 16'h4444;
    tb[0] = 16'h0F0F; tb[1] = 16'hF00F; tb[2] = 16'h3C3C; tb[3] = 16'h5A5A;

    cyc();
    cyc();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Single request, ideal Xor.
    a_in[0 +: DW] = 16'hA5A5;
    b_in[0 +: DW] = 16'h0FF0;
    req = 4'b0001;
    cyc();
    chk("t1_gnt", gnt, 4'b0001);
    req = 4'b0000;
    wait_done(10, n);
    chk("t1_latency", n, 4);
    chk("t1_result", result, 16'hAA55);
    chk("t1_result_id", result_id, 2'd0);
    cyc();
    chk("t1_done_pulse", done, 1'b0);
    cyc();
    chk("t1_idle", busy, 1'b0);

    // All four held continuously from a fresh pointer.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a_in[i*DW +: DW] = ta[i];
      b_in[i*DW +: DW] = tb[i];
    end
    req = 4'b1111;
    last_c = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(12, g);
      chk("t2_order", g, 4'b0001 << (k % NR));
      if (k > 0) chk("t2_spacing", cyc_n - last_c, 6);
      last_c = cyc_n;
      wait_done(10, n);
      chk("t2_result", result, ta[k % NR] ^ tb[k % NR]);
    end
    req = 4'b0000;
    wait_idle(10);

    // Pointer wrap: grant 2, then 0101 -> 0 then 2.
    req = 4'b0100;
    wait_gnt(12, g);
    chk("t3_first", g, 4'b0100);
    req = 4'b0101;
    wait_gnt(12, g);
    chk("t3_wrap", g, 4'b0001);
    wait_gnt(12, g);
    chk("t3_then2", g, 4'b0100);
    req = 4'b0000;
    wait_idle(10);

    // Reset mid-RUN at idx 2.
    a_in[1*DW +: DW] = 16'hC3A5;
    req = 4'b0010;
    wait_gnt(12, g);
    chk("t4_gnt1", g, 4'b0010);
    req = 4'b0000;
    cyc();
    cyc();
    chk("t4_idx2_chunk", chunk_a, 4'h3);
    rst_n = 1'b0;
    #1;
    chk("t4_async_gnt", gnt, 4'b0000);
    chk("t4_async_busy", busy, 1'b0);
    chk("t4_async_done", done, 1'b0);
    chk("t4_async_result", result, 16'h0000);
    chk("t4_async_chunk", chunk_a, 4'h0);
    chk("t4_async_id", result_id, 2'd0);
    cyc();
    cyc();
    chk("t4_no_done", done, 1'b0);
    rst_n = 1'b1;
    a_in[3*DW +: DW] = 16'h1234;
    b_in[3*DW +: DW] = 16'hF0F0;
    req = 4'b1010;
    wait_gnt(12, g);
    chk("t4_ptr_reset", g, 4'b0010);
    req = 4'b1000;
    wait_gnt(12, g);
    chk("t4_gnt3", g, 4'b1000);
    req = 4'b0000;
    wait_done(10, n);
    chk("t4_result", result, 16'hE2C4);
    chk("t4_result_id", result_id, 2'd3);
    wait_idle(10);

    // Boundary operands.
    a_in[0 +: DW] = 16'hFFFF;
    b_in[0 +: DW] = 16'hFFFF;
    req = 4'b0001;
    wait_gnt(12, g);
    req = 4'b0000;
    wait_done(10, n);
    chk("t5_ff_ff", result, 16'h0000);
    wait_idle(10);
    b_in[0 +: DW] = 16'h0000;
    req = 4'b0001;
    wait_gnt(12, g);
    req = 4'b0000;
    wait_done(10, n);
    chk("t5_ff_00", result, 16'hFFFF);
    wait_idle(10);

    // Broken Xor unit.
    fault_zero = 1'b1;
    a_in[0 +: DW] = 16'h1234;
    b_in[0 +: DW] = 16'h4321;
    req = 4'b0001;
    wait_gnt(12, g);
    req = 4'b0000;
    wait_done(10, n);
    chk("t6_result", result, 16'h0000);
    chk("t6_err", err, CHK);
    cyc();
    cyc();
    chk("t6_err_held", err, CHK);
    wait_idle(10);
    fault_zero = 1'b0;
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      a_in = {$urandom(), $urandom()};
      b_in = {$urandom(), $urandom()};
      cyc();
    end
    req = 4'b0000;
    wait_idle(10);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
